// File: rtl/eka_mem_arbiter_if.sv
// Bus bundle between the Eka core's fetch/load-store ports, the arbiter and the memory.
// Requests are held high until granted; each grant yields exactly one rvalid pulse later.
interface eka_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_gnt;
   logic                  i_rvalid;
   logic [31:0]           i_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [31:0]           d_wdata;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [31:0]           d_rdata;

   logic                  m_req;
   logic                  m_we;
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [31:0]           m_wdata;
   logic                  m_ack;
   logic [31:0]           m_rdata;

   // Arbiter side.
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      output m_req, m_we, m_addr, m_wdata
   );

   // Core and memory side.
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      input  m_req, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/eka_mem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and load/store.
// Data wins by default; a streak counter hands the memory to a waiting fetch every STREAK_MAX data grants.
module eka_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int STREAK_MAX = 4
) (
   input  logic               clk,
   input  logic               reset,
   eka_mem_arbiter_if.slave   bus,
   output logic               dbg_state
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);
   localparam logic       OWNER_I    = 1'b0;
   localparam logic       OWNER_D    = 1'b1;

   state_t                state_q;
   state_t                state_d;
   logic                  owner_q;
   logic [3:0]            streak_q;
   logic                  i_gnt;
   logic                  d_gnt;

   logic                  m_req_q;
   logic                  m_we_q;
   logic [ADDR_WIDTH-1:0] m_addr_q;
   logic [31:0]           m_wdata_q;
   logic                  i_rvalid_q;
   logic                  d_rvalid_q;
   logic [31:0]           i_rdata_q;
   logic [31:0]           d_rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grants exist only in IDLE, so a waiting request simply stays high through BUSY.
   always_comb begin
      state_d = state_q;
      i_gnt   = 1'b0;
      d_gnt   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.d_req && !(bus.i_req && streak_q == STREAK_LIM)) begin
               d_gnt = 1'b1;
            end else if (bus.i_req) begin
               i_gnt = 1'b1;
            end
            if (i_gnt || d_gnt) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (bus.m_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q    <= OWNER_I;
         streak_q   <= 4'd0;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= 32'd0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         i_rdata_q  <= 32'd0;
         d_rdata_q  <= 32'd0;
      end else begin
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;

         if (d_gnt) begin
            owner_q   <= OWNER_D;
            m_req_q   <= 1'b1;
            m_we_q    <= bus.d_we;
            m_addr_q  <= bus.d_addr;
            m_wdata_q <= bus.d_wdata;
            // A data grant with fetch waiting is only possible below the limit.
            if (bus.i_req) begin
               streak_q <= streak_q + 4'd1;
            end
         end else if (i_gnt) begin
            owner_q   <= OWNER_I;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= bus.i_addr;
            m_wdata_q <= 32'd0;
            streak_q  <= 4'd0;
         end

         if (state_q == BUSY && bus.m_ack) begin
            m_req_q <= 1'b0;
            m_we_q  <= 1'b0;
            if (owner_q == OWNER_D) begin
               d_rvalid_q <= 1'b1;
               d_rdata_q  <= m_we_q ? 32'd0 : bus.m_rdata;
            end else begin
               i_rvalid_q <= 1'b1;
               i_rdata_q  <= bus.m_rdata;
            end
         end
      end
   end

   assign bus.i_gnt    = i_gnt;
   assign bus.d_gnt    = d_gnt;
   assign bus.i_rvalid = i_rvalid_q;
   assign bus.d_rvalid = d_rvalid_q;
   assign bus.i_rdata  = i_rdata_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.m_req    = m_req_q;
   assign bus.m_we     = m_we_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_eka_mem_arbiter.sv
// Directed bench for eka_mem_arbiter: single fetch, store, contention, back-to-back, resets, spurious ack.
// Inputs change 1 ns after the rising edge; outputs are checked before the next edge.
module tb_eka_mem_arbiter;

   logic clk;
   logic reset;
   logic dbg_state;
   int   vectors;
   int   miscompares;

   eka_mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

   eka_mem_arbiter #(
      .ADDR_WIDTH(32),
      .STREAK_MAX(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.m_ack   = 1'b0;
      bus.m_rdata = '0;

      // Reset values
      tick();
      tick();
      check("rst_m_req",    32'(bus.m_req),    32'd0);
      check("rst_m_we",     32'(bus.m_we),     32'd0);
      check("rst_m_addr",   bus.m_addr,        32'd0);
      check("rst_m_wdata",  bus.m_wdata,       32'd0);
      check("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
      check("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      check("rst_i_rdata",  bus.i_rdata,       32'd0);
      check("rst_d_rdata",  bus.d_rdata,       32'd0);
      check("rst_state",    32'(dbg_state),    32'd0);
      check("rst_gnt",      32'({bus.i_gnt, bus.d_gnt}), 32'd0);
      reset = 1'b0;

      // Single fetch
      tick();
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h100;
      #1;
      check("f_i_gnt", 32'(bus.i_gnt), 32'd1);
      check("f_d_gnt", 32'(bus.d_gnt), 32'd0);
      tick();
      bus.i_req = 1'b0;
      check("f_m_req",  32'(bus.m_req), 32'd1);
      check("f_m_addr", bus.m_addr,     32'h100);
      check("f_m_we",   32'(bus.m_we),  32'd0);
      check("f_busy",   32'(dbg_state), 32'd1);
      #1;
      check("f_gnt_busy", 32'({bus.i_gnt, bus.d_gnt}), 32'd0);
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'hDEADBEEF;
      tick();
      bus.m_ack = 1'b0;
      check("f_i_rvalid", 32'(bus.i_rvalid), 32'd1);
      check("f_i_rdata",  bus.i_rdata,       32'hDEADBEEF);
      check("f_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      check("f_m_req_dn", 32'(bus.m_req),    32'd0);
      tick();
      check("f_i_rvalid_pulse", 32'(bus.i_rvalid), 32'd0);
      check("f_i_rdata_hold",   bus.i_rdata,       32'hDEADBEEF);

      // Store acked after three busy cycles
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h40;
      bus.d_wdata = 32'h12345678;
      #1;
      check("s_d_gnt", 32'(bus.d_gnt), 32'd1);
      tick();
      bus.d_req   = 1'b0;
      bus.m_rdata = 32'hFFFFFFFF;
      for (int k = 1; k <= 3; k++) begin
         check("s_m_req",   32'(bus.m_req), 32'd1);
         check("s_m_we",    32'(bus.m_we),  32'd1);
         check("s_m_addr",  bus.m_addr,     32'h40);
         check("s_m_wdata", bus.m_wdata,    32'h12345678);
         check("s_d_rvalid_wait", 32'(bus.d_rvalid), 32'd0);
         if (k == 3) bus.m_ack = 1'b1;
         tick();
      end
      bus.m_ack = 1'b0;
      check("s_d_rvalid", 32'(bus.d_rvalid), 32'd1);
      check("s_d_rdata",  bus.d_rdata,       32'd0);
      check("s_m_req_dn", 32'(bus.m_req),    32'd0);
      bus.d_we = 1'b0;

      // Contention: expected grant order D D D D I, repeated
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h200;
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h300;
      for (int n = 0; n < 10; n++) begin
         logic exp_d;
         exp_d = ((n % 5) != 4);
         #1;
         check("c_d_gnt", 32'(bus.d_gnt), 32'(exp_d));
         check("c_i_gnt", 32'(bus.i_gnt), 32'(!exp_d));
         tick();
         check("c_m_addr", bus.m_addr, exp_d ? 32'h300 : 32'h200);
         bus.m_ack   = 1'b1;
         bus.m_rdata = 32'(n + 16);
         tick();
         bus.m_ack = 1'b0;
         check("c_d_rvalid", 32'(bus.d_rvalid), 32'(exp_d));
         check("c_i_rvalid", 32'(bus.i_rvalid), 32'(!exp_d));
         check("c_rdata", exp_d ? bus.d_rdata : bus.i_rdata, 32'(n + 16));
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      tick();

      // Back-to-back loads
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h80;
      for (int n = 1; n <= 3; n++) begin
         #1;
         check("b_d_gnt", 32'(bus.d_gnt), 32'd1);
         tick();
         check("b_d_rvalid_busy", 32'(bus.d_rvalid), 32'd0);
         bus.m_ack   = 1'b1;
         bus.m_rdata = 32'(n);
         tick();
         bus.m_ack = 1'b0;
         check("b_d_rvalid", 32'(bus.d_rvalid), 32'd1);
         check("b_d_rdata",  bus.d_rdata,       32'(n));
      end
      bus.d_req = 1'b0;
      tick();
      check("b_d_rvalid_end", 32'(bus.d_rvalid), 32'd0);
      check("b_d_rdata_hold", bus.d_rdata,       32'd3);

      // Reset while BUSY, late ack ignored
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h500;
      #1;
      check("r_i_gnt", 32'(bus.i_gnt), 32'd1);
      tick();
      bus.i_req = 1'b0;
      check("r_m_req", 32'(bus.m_req), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("r_m_req_dn", 32'(bus.m_req),    32'd0);
      check("r_state",    32'(dbg_state),    32'd0);
      check("r_m_addr",   bus.m_addr,        32'd0);
      check("r_i_rvalid", 32'(bus.i_rvalid), 32'd0);
      check("r_i_rdata",  bus.i_rdata,       32'd0);
      check("r_d_rdata",  bus.d_rdata,       32'd0);
      tick();
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'hCAFEF00D;
      tick();
      bus.m_ack = 1'b0;
      check("r_late_i_rvalid", 32'(bus.i_rvalid), 32'd0);
      check("r_late_i_rdata",  bus.i_rdata,       32'd0);
      check("r_late_m_req",    32'(bus.m_req),    32'd0);

      // Reset in the same cycle as m_ack
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h600;
      tick();
      bus.i_req   = 1'b0;
      check("ra_m_req", 32'(bus.m_req), 32'd1);
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'h0BADF00D;
      reset       = 1'b1;
      tick();
      reset     = 1'b0;
      bus.m_ack = 1'b0;
      check("ra_i_rvalid", 32'(bus.i_rvalid), 32'd0);
      check("ra_i_rdata",  bus.i_rdata,       32'd0);
      check("ra_m_req_dn", 32'(bus.m_req),    32'd0);

      // Spurious ack in IDLE
      tick();
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'h55AA55AA;
      tick();
      bus.m_ack = 1'b0;
      check("sp_i_rvalid", 32'(bus.i_rvalid), 32'd0);
      check("sp_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      check("sp_state",    32'(dbg_state),    32'd0);
      check("sp_m_req",    32'(bus.m_req),    32'd0);
      check("sp_i_rdata",  bus.i_rdata,       32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
